calc_operand_loader: RTL and testbench
======================================

# calc_operand_loader

Sequential front/back end for the combinational `rem` unit in the logic calculator. It collects two signed operands from a keypad-style key stream and presents them to `rem` as 3-bit sign-magnitude values. It then captures `rem`'s result and flags into registers and holds them under a valid/ack handshake until the display side consumes them.

## Interface

- `MAG_W`, default 2: operand magnitude width; operand width is `MAG_W+1`, with the sign in the MSB.
- `RES_W`, default 4: result width from `rem`, with the sign in the MSB.

- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous reset, active-low.
- `key_valid`, in, 1: key present this cycle.
- `key_code`, in, 4: 0x0–0x3 digit, 0xA minus, 0xE enter, 0xC clear; all other codes are ignored.
- `key_ready`, out, 1: key accepted when `key_valid & key_ready`.
- `num_a`, out, `MAG_W+1`: operand A to `rem` `NumA`.
- `num_b`, out, `MAG_W+1`: operand B to `rem` `NumB`.
- `ops_valid`, out, 1: one-cycle pulse; operands committed and `rem` is being sampled.
- `res_in`, in, `RES_W`: `rem` `Res`.
- `neg_in`, `zer_in`, `dz_in`, in, 1 each: `rem` `negF`, `zerF`, `DZF`.
- `result`, out, `RES_W`: registered result.
- `neg_f`, `zer_f`, `dz_f`, out, 1 each: registered flags.
- `result_valid`, out, 1: result held for consumer.
- `result_ack`, in, 1: consumer takes the result.

## Operation

- States:
  - ENTER_A: edit operand A.
  - ENTER_B: edit operand B.
  - ISSUE: present operands to `rem` and sample its outputs.
  - HOLD: present the captured result.
- Reset: all outputs are 0 and the state is ENTER_A. An asserted `rst_n` mid-operation aborts immediately, with no partial result kept.
- `key_ready` is 1 in ENTER_A and ENTER_B, and 0 in ISSUE and HOLD.
- Keys are only acted on when accepted:
  - Digit: magnitude of the field being edited is set to `key_code[MAG_W-1:0]`. The last digit wins; there is no accumulation.
  - Minus: toggles the sign of the field being edited.
  - Enter: commits the field. If the magnitude is 0, the sign is forced to 0 (no negative zero). ENTER_A goes to ENTER_B; ENTER_B goes to ISSUE.
  - Clear: A and B are set to 0 and the state goes to ENTER_A.
  - Any other code: consumed with no effect.
- Editing is performed directly on `num_a` / `num_b` registers, which are therefore visible while typing. `ops_valid` alone qualifies them for use.
- ISSUE lasts exactly one cycle:
  - `ops_valid` = 1.
  - At the closing edge, `res_in` and the three flag inputs are registered into `result` and the flags.
  - The state goes to HOLD.
- HOLD:
  - `result_valid` = 1, with result and flags stable.
  - `num_a` and `num_b` are held unchanged.
  - On `result_ack`, the next state is ENTER_A: `num_a`, `num_b` and `result_valid` are cleared, while `result` and the flags keep their last value.
- `result_ack` outside HOLD is ignored.
- No arithmetic is performed here. Operand checking, including divide-by-zero, is `rem`'s job; `dz_f` is passed through from `dz_in`.

## Timing

- For enter accepted on B in cycle t:
  - ISSUE in t+1 (`ops_valid` = 1).
  - Result registered at the end of t+1.
  - `result_valid` = 1 from t+2.
- Key-to-field latency is 1 cycle: the field value changes at the edge after acceptance.
- `result_ack` in cycle h (HOLD) gives `result_valid` = 0 and `key_ready` = 1 at h+1. A key can be accepted in h+1.
- `rem` is combinational. Operands are stable for at least the full ISSUE cycle, which is sufficient.
- `result_valid` stays high indefinitely without `result_ack`; no timeout.

## Structure

- Package `calc_pkg` holds:
  - Key-code constants (`KEY_MINUS`, `KEY_ENTER`, `KEY_CLEAR`).
  - The state enum.
  - `MAG_W` / `RES_W` defaults, shared with `rem` and the display side.
- One natural sub-module, `calc_operand_field`: sign/magnitude edit register with digit, minus, commit-normalize and clear. It is instantiated twice, once for A and once for B, each enabled by state.
- The top level contains the FSM, the result capture registers and the handshake.

## Test plan

- Keys `A,3,E,2,E` with `rem` model: `num_a`=3'b111, `num_b`=3'b010. `ops_valid` pulses one cycle. Then `result`=4'b1001 and `neg_f`=1, with `result_valid` held until ack.
- Keys `1,E,0,E`: `num_b`=3'b000, `dz_f`=1 and `result_valid`=1. Ack returns to ENTER_A with `num_a`=0.
- Keys `A,0,E`: `num_a`=3'b000 (negative zero normalized). Keys `A,A,2,E`: `num_a`=3'b010.
- Keys `1,3,7,E`: `num_a`=3'b011; 0x7 is consumed with no effect.
- Keys `2,E,1` then `C`: state ENTER_A, `num_a`=`num_b`=0, `ops_valid` never pulses.
- `rst_n` low in HOLD: all outputs 0 asynchronously. After release, `key_ready`=1. `result_ack` asserted in ENTER_A has no effect.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared key codes, FSM state encoding and width defaults for
//                the logic calculator (operand loader, rem, display side).
//  Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    // Width defaults shared by the loader, rem and the display side
    localparam int DEFAULT_MAG_W = 2;
    localparam int DEFAULT_RES_W = 4;

    // Key codes; digits occupy 0x0 .. KEY_DIGIT_MAX
    localparam logic [3:0] KEY_DIGIT_MAX = 4'h3;
    localparam logic [3:0] KEY_MINUS     = 4'hA;
    localparam logic [3:0] KEY_ENTER     = 4'hE;
    localparam logic [3:0] KEY_CLEAR     = 4'hC;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        ISSUE   = 2'd2,
        HOLD    = 2'd3
    } state_t;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/calc_operand_field.sv
`default_nettype none
// ============================================================================
//  Module      : calc_operand_field
//  Description : Sign/magnitude operand edit register. A digit overwrites the
//                magnitude, minus toggles the sign, enter normalizes negative
//                zero to positive zero, clear zeroes the field.
//  Ports       : clk, rst_n     - clock, async active-low reset
//                edit_en        - accepted key targets this field
//                clear          - synchronous clear (priority over edit_en)
//                key_code       - key being applied
//                value          - {sign, magnitude}
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_operand_field
    import calc_pkg::*;
#(
    parameter int MAG_W = DEFAULT_MAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             edit_en,
    input  logic             clear,
    input  logic [3:0]       key_code,
    output logic [MAG_W:0]   value
);

    logic             sign;
    logic [MAG_W-1:0] mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign <= 1'b0;
            mag  <= '0;
        end else if (clear) begin
            sign <= 1'b0;
            mag  <= '0;
        end else if (edit_en) begin
            if (key_code <= KEY_DIGIT_MAX) begin
                // Last digit wins; no decimal accumulation
                mag <= key_code[MAG_W-1:0];
            end else if (key_code == KEY_MINUS) begin
                sign <= ~sign;
            end else if (key_code == KEY_ENTER) begin
                if (mag == '0) begin
                    sign <= 1'b0;
                end
            end
            // Any other code is consumed without effect
        end
    end

    assign value = {sign, mag};

endmodule : calc_operand_field
`default_nettype wire

// File: rtl/calc_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : calc_operand_loader
//  Description : Collects two signed operands from a key stream, presents them
//                to the combinational rem unit for one ISSUE cycle, captures
//                its result/flags and holds them under a valid/ack handshake.
//  Ports       : clk, rst_n               - clock, async active-low reset
//                key_valid/key_code/key_ready - key stream handshake
//                num_a, num_b, ops_valid   - operands to rem and qualifier
//                res_in, neg_in, zer_in, dz_in - rem outputs
//                result, neg_f, zer_f, dz_f    - captured result and flags
//                result_valid, result_ack      - consumer handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_operand_loader
    import calc_pkg::*;
#(
    parameter int MAG_W = DEFAULT_MAG_W,
    parameter int RES_W = DEFAULT_RES_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic             key_ready,
    output logic [MAG_W:0]   num_a,
    output logic [MAG_W:0]   num_b,
    output logic             ops_valid,
    input  logic [RES_W-1:0] res_in,
    input  logic             neg_in,
    input  logic             zer_in,
    input  logic             dz_in,
    output logic [RES_W-1:0] result,
    output logic             neg_f,
    output logic             zer_f,
    output logic             dz_f,
    output logic             result_valid,
    input  logic             result_ack
);

    state_t state;

    logic key_accept;
    logic clear_fields;
    logic edit_a;
    logic edit_b;

    // key_ready is only high in the two edit states, so acceptance implies
    // the state is ENTER_A or ENTER_B.
    assign key_accept   = key_valid & key_ready;
    assign edit_a       = key_accept & (state == ENTER_A);
    assign edit_b       = key_accept & (state == ENTER_B);
    // Both fields clear on a clear key or when the held result is consumed
    assign clear_fields = (key_accept & (key_code == KEY_CLEAR)) |
                          ((state == HOLD) & result_ack);

    calc_operand_field #(.MAG_W(MAG_W)) u_field_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .edit_en  (edit_a),
        .clear    (clear_fields),
        .key_code (key_code),
        .value    (num_a)
    );

    calc_operand_field #(.MAG_W(MAG_W)) u_field_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .edit_en  (edit_b),
        .clear    (clear_fields),
        .key_code (key_code),
        .value    (num_b)
    );

    // FSM with registered handshake outputs and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ENTER_A;
            key_ready    <= 1'b0;
            ops_valid    <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            neg_f        <= 1'b0;
            zer_f        <= 1'b0;
            dz_f         <= 1'b0;
        end else begin
            ops_valid <= 1'b0;
            case (state)
                ENTER_A: begin
                    // Also raises key_ready on the first edge after reset
                    key_ready <= 1'b1;
                    if (key_accept && key_code == KEY_ENTER) begin
                        state <= ENTER_B;
                    end
                end
                ENTER_B: begin
                    key_ready <= 1'b1;
                    if (key_accept) begin
                        if (key_code == KEY_CLEAR) begin
                            state <= ENTER_A;
                        end else if (key_code == KEY_ENTER) begin
                            state     <= ISSUE;
                            key_ready <= 1'b0;
                            ops_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // rem is combinational on the stable operands
                    result       <= res_in;
                    neg_f        <= neg_in;
                    zer_f        <= zer_in;
                    dz_f         <= dz_in;
                    result_valid <= 1'b1;
                    state        <= HOLD;
                end
                HOLD: begin
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        key_ready    <= 1'b1;
                        state        <= ENTER_A;
                    end
                end
                default: begin
                    state     <= ENTER_A;
                    key_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule : calc_operand_loader
`default_nettype wire

// File: tb/tb_calc_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc_operand_loader
//  Description : Directed self-checking bench for calc_operand_loader with a
//                small behavioural rem unit attached.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_operand_loader;

    logic       clk;
    logic       rst_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [2:0] num_a;
    logic [2:0] num_b;
    logic       ops_valid;
    logic [3:0] res_in;
    logic       neg_in;
    logic       zer_in;
    logic       dz_in;
    logic [3:0] result;
    logic       neg_f;
    logic       zer_f;
    logic       dz_f;
    logic       result_valid;
    logic       result_ack;

    int errors = 0;
    int checks = 0;
    int ops_cnt = 0;

    calc_operand_loader #(.MAG_W(2), .RES_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_ready    (key_ready),
        .num_a        (num_a),
        .num_b        (num_b),
        .ops_valid    (ops_valid),
        .res_in       (res_in),
        .neg_in       (neg_in),
        .zer_in       (zer_in),
        .dz_in        (dz_in),
        .result       (result),
        .neg_f        (neg_f),
        .zer_f        (zer_f),
        .dz_f         (dz_f),
        .result_valid (result_valid),
        .result_ack   (result_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural rem: remainder carries the dividend's sign
    always_comb begin
        logic [1:0] m;
        res_in = 4'b0000;
        neg_in = 1'b0;
        zer_in = 1'b0;
        dz_in  = 1'b0;
        m      = 2'b00;
        if (num_b[1:0] == 2'b00) begin
            dz_in = 1'b1;
        end else begin
            m      = num_a[1:0] % num_b[1:0];
            res_in = {num_a[2] && (m != 2'b00), 1'b0, m};
            neg_in = res_in[3];
            zer_in = (m == 2'b00);
        end
    end

    always @(negedge clk) if (ops_valid) ops_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        int n;
        n = 0;
        while (key_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (key_ready !== 1'b1) begin
            errors++;
            checks++;
            $display("FAIL press_wait: key_ready=%b required 1", key_ready);
        end
        key_valid = 1'b1;
        key_code  = code;
        step();
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic ack();
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({key_ready, num_a, num_b, ops_valid, result_valid, result, neg_f, zer_f, dz_f} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got kr=%b a=%b b=%b ov=%b rv=%b r=%b n=%b z=%b d=%b required all 0",
                     key_ready, num_a, num_b, ops_valid, result_valid, result, neg_f, zer_f, dz_f);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (key_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_key_ready: got %b required 1", key_ready);
        end
    endtask

    task automatic test_basic();
        int base;
        press(4'hA); press(4'h3); press(4'hE); press(4'h2);
        checks++;
        if (num_a !== 3'b111) begin
            errors++; $display("FAIL basic_num_a: got %b required 111", num_a);
        end
        checks++;
        if (num_b !== 3'b010) begin
            errors++; $display("FAIL basic_num_b: got %b required 010", num_b);
        end
        base = ops_cnt;
        press(4'hE);
        checks++;
        if ({ops_valid, key_ready, result_valid} !== 3'b100) begin
            errors++; $display("FAIL basic_issue: ov/kr/rv got %b required 100", {ops_valid, key_ready, result_valid});
        end
        step();
        checks++;
        if ({ops_valid, result_valid, result, neg_f, zer_f, dz_f} !== 9'b0_1_1001_100) begin
            errors++; $display("FAIL basic_result: ov=%b rv=%b r=%b n=%b z=%b d=%b required 0 1 1001 1 0 0",
                               ops_valid, result_valid, result, neg_f, zer_f, dz_f);
        end
        repeat (4) step();
        checks++;
        if (result_valid !== 1'b1 || result !== 4'b1001 || ops_cnt != base + 1 || num_a !== 3'b111) begin
            errors++; $display("FAIL basic_hold: rv=%b r=%b pulses=%0d a=%b required 1 1001 1 111",
                               result_valid, result, ops_cnt - base, num_a);
        end
        ack();
        checks++;
        if ({result_valid, key_ready, num_a, num_b, result, neg_f} !== 13'b0_1_000_000_1001_1) begin
            errors++; $display("FAIL basic_ack: rv=%b kr=%b a=%b b=%b r=%b n=%b required 0 1 000 000 1001 1",
                               result_valid, key_ready, num_a, num_b, result, neg_f);
        end
        // back-to-back: key accepted in the cycle right after ack
        press(4'h1);
        checks++;
        if (num_a !== 3'b001) begin
            errors++; $display("FAIL back_to_back: num_a got %b required 001", num_a);
        end
        press(4'hC);
    endtask

    task automatic test_div_zero();
        press(4'h1); press(4'hE); press(4'h0); press(4'hE);
        step();
        checks++;
        if ({num_b, dz_f, result_valid} !== 5'b000_1_1) begin
            errors++; $display("FAIL dz: b=%b dz=%b rv=%b required 000 1 1", num_b, dz_f, result_valid);
        end
        ack();
        checks++;
        if (num_a !== 3'b000 || result_valid !== 1'b0 || dz_f !== 1'b1) begin
            errors++; $display("FAIL dz_ack: a=%b rv=%b dz=%b required 000 0 1", num_a, result_valid, dz_f);
        end
    endtask

    task automatic test_neg_zero();
        press(4'hA); press(4'h0);
        checks++;
        if (num_a !== 3'b100) begin
            errors++; $display("FAIL negzero_typing: num_a got %b required 100", num_a);
        end
        press(4'hE);
        checks++;
        if (num_a !== 3'b000) begin
            errors++; $display("FAIL negzero_commit: num_a got %b required 000", num_a);
        end
        press(4'hC);
        press(4'hA); press(4'hA); press(4'h2); press(4'hE);
        checks++;
        if (num_a !== 3'b010) begin
            errors++; $display("FAIL double_minus: num_a got %b required 010", num_a);
        end
        press(4'hC);
    endtask

    task automatic test_ignored_code();
        press(4'h1); press(4'h3); press(4'h7); press(4'hE);
        checks++;
        if (num_a !== 3'b011) begin
            errors++; $display("FAIL ignored_code: num_a got %b required 011", num_a);
        end
        press(4'hC);
    endtask

    task automatic test_clear();
        int base;
        base = ops_cnt;
        press(4'h2); press(4'hE); press(4'h1);
        checks++;
        if (num_b !== 3'b001) begin
            errors++; $display("FAIL clear_setup: num_b got %b required 001", num_b);
        end
        press(4'hC);
        checks++;
        if ({num_a, num_b, key_ready} !== 7'b000_000_1) begin
            errors++; $display("FAIL clear_fields: a=%b b=%b kr=%b required 000 000 1", num_a, num_b, key_ready);
        end
        // a digit now must land in A, proving the state went back to ENTER_A
        press(4'h3);
        checks++;
        if (num_a !== 3'b011 || num_b !== 3'b000 || ops_cnt != base) begin
            errors++; $display("FAIL clear_state: a=%b b=%b pulses=%0d required 011 000 0",
                               num_a, num_b, ops_cnt - base);
        end
        press(4'hC);
    endtask

    task automatic test_reset_in_hold();
        press(4'h1); press(4'hE); press(4'h1); press(4'hE);
        step();
        checks++;
        if (result_valid !== 1'b1) begin
            errors++; $display("FAIL hold_entry: result_valid got %b required 1", result_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({key_ready, num_a, num_b, ops_valid, result_valid, result, neg_f, zer_f, dz_f} !== 16'h0) begin
            errors++; $display("FAIL async_reset: kr=%b a=%b b=%b rv=%b r=%b z=%b required all 0",
                               key_ready, num_a, num_b, result_valid, result, zer_f);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (key_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release: key_ready got %b required 1", key_ready);
        end
        press(4'h2);
        ack();
        checks++;
        if ({num_a, result_valid, key_ready} !== 5'b010_0_1) begin
            errors++; $display("FAIL ack_outside_hold: a=%b rv=%b kr=%b required 010 0 1",
                               num_a, result_valid, key_ready);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        key_valid  = 1'b0;
        key_code   = 4'h0;
        result_ack = 1'b0;
        test_reset();
        test_basic();
        test_div_zero();
        test_neg_zero();
        test_ignored_code();
        test_clear();
        test_reset_in_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_calc_operand_loader
`default_nettype wire
